decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 34 +++
 rtl/decode_stage_if.sv | 49 ++++
 rtl/decode_stage_control_decoder.sv | 58 +++++
 rtl/decode_stage.sv | 104 ++++++++++
 tb/tb_decode_stage.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared cpu constants: widths, opcodes, aluOp codes, control bundle
package decode_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic is_opcode(input logic [5:0] field, input opcode_e op);
        return field == op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - IF/ID slot, register file read port and ID/EX outputs of the decode stage
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;

    logic [RA_W-1:0] addressA;
    logic [RA_W-1:0] addressB;
    logic [XLEN-1:0] dataA;
    logic [XLEN-1:0] dataB;

    logic            stall;

    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rsData;
    logic [XLEN-1:0] out_rtData;
    logic [XLEN-1:0] out_imm;
    logic [RA_W-1:0] out_rs;
    logic [RA_W-1:0] out_rt;
    logic [RA_W-1:0] out_dest;
    logic            out_regWrite;
    logic            out_memRead;
    logic            out_memWrite;
    logic            out_aluSrc;
    logic            out_branch;
    logic [1:0]      out_aluOp;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, dataA, dataB,
        output addressA, addressB, stall,
        output out_valid, out_pc, out_rsData, out_rtData, out_imm,
        output out_rs, out_rt, out_dest,
        output out_regWrite, out_memRead, out_memWrite, out_aluSrc, out_branch, out_aluOp
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, dataA, dataB,
        input  addressA, addressB, stall,
        input  out_valid, out_pc, out_rsData, out_rtData, out_imm,
        input  out_rs, out_rt, out_dest,
        input  out_regWrite, out_memRead, out_memWrite, out_aluSrc, out_branch, out_aluOp
    );

endinterface

// File: rtl/decode_stage_control_decoder.sv
// rtl/decode_stage_control_decoder.sv - opcode to control bits, source-use flags and destination select
module control_decoder
    import decode_stage_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic [5:0]      opcode,
    input  logic [RA_W-1:0] rt,
    input  logic [RA_W-1:0] rd,
    output ctrl_t           ctrl,
    output logic            use_rs,
    output logic            use_rt,
    output logic [RA_W-1:0] dest
);

    always_comb begin
        ctrl   = CTRL_NOP;
        use_rs = 1'b0;
        use_rt = 1'b0;
        dest   = '0;
        if (is_opcode(opcode, OP_RTYPE)) begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
            use_rs         = 1'b1;
            use_rt         = 1'b1;
            dest           = rd;
        end else if (is_opcode(opcode, OP_LW)) begin
            ctrl.reg_write = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
            use_rs         = 1'b1;
            dest           = rt;
        end else if (is_opcode(opcode, OP_SW)) begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
            use_rs         = 1'b1;
            use_rt         = 1'b1;
        end else if (is_opcode(opcode, OP_BEQ)) begin
            ctrl.branch    = 1'b1;
            ctrl.alu_op    = ALUOP_SUB;
            use_rs         = 1'b1;
            use_rt         = 1'b1;
        end else if (is_opcode(opcode, OP_ADDI)) begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
            use_rs         = 1'b1;
            dest           = rt;
        end
        // r0 is hardwired to zero, so a write to it is dropped here once for all consumers
        if (dest == '0) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with load-use hazard detection and the ID/EX register
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);

    logic [5:0]      opcode;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] imm_ext;

    assign opcode  = bus.in_instr[31:26];
    assign rs      = bus.in_instr[21 +: RA_W];
    assign rt      = bus.in_instr[16 +: RA_W];
    assign rd      = bus.in_instr[11 +: RA_W];
    assign imm_ext = {{(XLEN-16){bus.in_instr[15]}}, bus.in_instr[15:0]};

    assign bus.addressA = rs;
    assign bus.addressB = rt;

    ctrl_t           dec_ctrl;
    logic            use_rs;
    logic            use_rt;
    logic [RA_W-1:0] dec_dest;

    control_decoder #(.RA_W(RA_W)) u_control_decoder (
        .opcode (opcode),
        .rt     (rt),
        .rd     (rd),
        .ctrl   (dec_ctrl),
        .use_rs (use_rs),
        .use_rt (use_rt),
        .dest   (dec_dest)
    );

    logic            idex_valid;
    ctrl_t           idex_ctrl;
    logic [XLEN-1:0] idex_pc;
    logic [XLEN-1:0] idex_rs_data;
    logic [XLEN-1:0] idex_rt_data;
    logic [XLEN-1:0] idex_imm;
    logic [RA_W-1:0] idex_rs;
    logic [RA_W-1:0] idex_rt;
    logic [RA_W-1:0] idex_dest;

    logic load_use;
    logic stall;
    logic bubble;

    // A load in EX cannot forward its data in time, so the dependent instruction waits one cycle
    assign load_use = idex_valid && idex_ctrl.mem_read && (idex_dest != '0) && bus.in_valid &&
                      ((use_rs && (rs == idex_dest)) || (use_rt && (rt == idex_dest)));
    assign stall    = load_use && !bus.flush;
    assign bubble   = bus.flush || stall || !bus.in_valid;

    assign bus.stall = stall;

    always_ff @(posedge clk) begin
        if (!rst || bubble) begin
            idex_valid   <= 1'b0;
            idex_ctrl    <= CTRL_NOP;
            idex_pc      <= '0;
            idex_rs_data <= '0;
            idex_rt_data <= '0;
            idex_imm     <= '0;
            idex_rs      <= '0;
            idex_rt      <= '0;
            idex_dest    <= '0;
        end else begin
            idex_valid   <= 1'b1;
            idex_ctrl    <= dec_ctrl;
            idex_pc      <= bus.in_pc;
            idex_rs_data <= bus.dataA;
            idex_rt_data <= bus.dataB;
            idex_imm     <= imm_ext;
            idex_rs      <= rs;
            idex_rt      <= rt;
            idex_dest    <= dec_dest;
        end
    end

    assign bus.out_valid    = idex_valid;
    assign bus.out_pc       = idex_pc;
    assign bus.out_rsData   = idex_rs_data;
    assign bus.out_rtData   = idex_rt_data;
    assign bus.out_imm      = idex_imm;
    assign bus.out_rs       = idex_rs;
    assign bus.out_rt       = idex_rt;
    assign bus.out_dest     = idex_dest;
    assign bus.out_regWrite = idex_ctrl.reg_write;
    assign bus.out_memRead  = idex_ctrl.mem_read;
    assign bus.out_memWrite = idex_ctrl.mem_write;
    assign bus.out_aluSrc   = idex_ctrl.alu_src;
    assign bus.out_branch   = idex_ctrl.branch;
    assign bus.out_aluOp    = idex_ctrl.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with directed instruction vectors
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [6:0]  ctrl;
    } exp_t;

    typedef struct packed {
        logic       stall;
        logic [4:0] addr_a;
        logic [4:0] addr_b;
        exp_t       idex;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    rec_t sb_q[$];
    exp_t pending = '0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .RA_W(5)) bus ();

    decode_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic exp_t mk(input logic v, input logic [31:0] pc, rsd, rtd, imm,
                                input logic [4:0] rs, rt, dest, input logic [6:0] ctrl);
        exp_t e;
        e.valid = v; e.pc = pc; e.rsd = rsd; e.rtd = rtd; e.imm = imm;
        e.rs = rs; e.rt = rt; e.dest = dest; e.ctrl = ctrl;
        return e;
    endfunction

    task automatic step(input logic r, v, f, input logic [31:0] instr, pc, da, db,
                        input logic es, input logic [4:0] ea, eb, input exp_t eo);
        rec_t rc;
        @(posedge clk);
        #1;
        rst = r; bus.in_valid = v; bus.flush = f; bus.in_instr = instr;
        bus.in_pc = pc; bus.dataA = da; bus.dataB = db;
        rc.stall = es; rc.addr_a = ea; rc.addr_b = eb; rc.idex = pending;
        sb_q.push_back(rc);
        pending = eo;
    endtask

    initial begin : monitor
        rec_t rc;
        exp_t act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                rc = sb_q.pop_front();
                act = mk(bus.out_valid, bus.out_pc, bus.out_rsData, bus.out_rtData, bus.out_imm,
                         bus.out_rs, bus.out_rt, bus.out_dest,
                         {bus.out_regWrite, bus.out_memRead, bus.out_memWrite, bus.out_aluSrc,
                          bus.out_branch, bus.out_aluOp});
                checks++;
                if (bus.stall !== rc.stall) begin
                    errors++;
                    $display("FAIL stall t=%0t got=%b want=%b", $time, bus.stall, rc.stall);
                end
                checks++;
                if (bus.addressA !== rc.addr_a) begin
                    errors++;
                    $display("FAIL addressA t=%0t got=%0d want=%0d", $time, bus.addressA, rc.addr_a);
                end
                checks++;
                if (bus.addressB !== rc.addr_b) begin
                    errors++;
                    $display("FAIL addressB t=%0t got=%0d want=%0d", $time, bus.addressB, rc.addr_b);
                end
                checks++;
                if (act !== rc.idex) begin
                    errors++;
                    $display("FAIL idex t=%0t got v=%b pc=%h rs=%h rt=%h imm=%h r=%0d/%0d d=%0d c=%b want v=%b pc=%h rs=%h rt=%h imm=%h r=%0d/%0d d=%0d c=%b",
                             $time, act.valid, act.pc, act.rsd, act.rtd, act.imm, act.rs, act.rt, act.dest, act.ctrl,
                             rc.idex.valid, rc.idex.pc, rc.idex.rsd, rc.idex.rtd, rc.idex.imm,
                             rc.idex.rs, rc.idex.rt, rc.idex.dest, rc.idex.ctrl);
                end
            end
        end
    end

    initial begin : driver
        exp_t z;
        z = '0;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.dataA = '0; bus.dataB = '0;
        // control order: regWrite memRead memWrite aluSrc branch aluOp[1:0]
        step(0,0,0,32'h0,       32'h0,  32'h0,  32'h0,  0, 0, 0, z);
        step(1,0,0,32'h0,       32'h0,  32'h0,  32'h0,  0, 0, 0, z);
        step(1,1,0,32'h2143FFFC,32'h100,32'h5,  32'h7,  0,10, 3, mk(1,32'h100,32'h5,32'h7,32'hFFFFFFFC,10,3,3,7'b1001000));
        step(1,1,0,32'h8C240000,32'h104,32'h40, 32'h9,  0, 1, 4, mk(1,32'h104,32'h40,32'h9,32'h0,1,4,4,7'b1101000));
        step(1,1,0,32'h00822820,32'h108,32'h1,  32'h2,  1, 4, 2, z);
        step(1,1,0,32'h00822820,32'h108,32'h11, 32'h22, 0, 4, 2, mk(1,32'h108,32'h11,32'h22,32'h2820,4,2,5,7'b1000010));
        step(1,1,0,32'h8C200000,32'h10C,32'h40, 32'h3,  0, 1, 0, mk(1,32'h10C,32'h40,32'h3,32'h0,1,0,0,7'b0101000));
        step(1,1,0,32'h00002820,32'h110,32'h0,  32'h0,  0, 0, 0, mk(1,32'h110,32'h0,32'h0,32'h2820,0,0,5,7'b1000010));
        step(1,1,0,32'h8C240000,32'h114,32'h80, 32'h0,  0, 1, 4, mk(1,32'h114,32'h80,32'h0,32'h0,1,4,4,7'b1101000));
        step(1,1,1,32'h00822820,32'h118,32'h1,  32'h2,  0, 4, 2, z);
        step(1,1,0,32'h8C240000,32'h11C,32'h80, 32'h0,  0, 1, 4, mk(1,32'h11C,32'h80,32'h0,32'h0,1,4,4,7'b1101000));
        step(0,1,0,32'h00822820,32'h120,32'h1,  32'h2,  1, 4, 2, z);
        step(1,1,0,32'h00822820,32'h120,32'h3,  32'h4,  0, 4, 2, mk(1,32'h120,32'h3,32'h4,32'h2820,4,2,5,7'b1000010));
        step(1,1,0,32'hAC240008,32'h124,32'h50, 32'h60, 0, 1, 4, mk(1,32'h124,32'h50,32'h60,32'h8,1,4,0,7'b0011000));
        step(1,1,0,32'h1022FFFF,32'h128,32'h1,  32'h2,  0, 1, 2, mk(1,32'h128,32'h1,32'h2,32'hFFFFFFFF,1,2,0,7'b0000101));
        step(1,1,0,32'hFC000000,32'h12C,32'hA,  32'hB,  0, 0, 0, mk(1,32'h12C,32'hA,32'hB,32'h0,0,0,0,7'b0000000));
        step(1,1,0,32'h00220020,32'h130,32'h1,  32'h2,  0, 1, 2, mk(1,32'h130,32'h1,32'h2,32'h20,1,2,0,7'b0000010));
        step(1,1,0,32'h8C240000,32'h134,32'h90, 32'h0,  0, 1, 4, mk(1,32'h134,32'h90,32'h0,32'h0,1,4,4,7'b1101000));
        step(1,1,0,32'hAC240008,32'h138,32'h1,  32'h2,  1, 1, 4, z);
        step(1,1,0,32'hAC240008,32'h138,32'h5,  32'h6,  0, 1, 4, mk(1,32'h138,32'h5,32'h6,32'h8,1,4,0,7'b0011000));
        step(1,1,0,32'h8C240000,32'h13C,32'h90, 32'h0,  0, 1, 4, mk(1,32'h13C,32'h90,32'h0,32'h0,1,4,4,7'b1101000));
        step(1,1,0,32'h20240001,32'h140,32'h7,  32'h8,  0, 1, 4, mk(1,32'h140,32'h7,32'h8,32'h1,1,4,4,7'b1001000));
        step(1,1,0,32'h8C240000,32'h144,32'h90, 32'h0,  0, 1, 4, mk(1,32'h144,32'h90,32'h0,32'h0,1,4,4,7'b1101000));
        step(1,0,0,32'h00822820,32'h148,32'h1,  32'h2,  0, 4, 2, z);
        step(1,0,0,32'h0,       32'h0,  32'h0,  32'h0,  0, 0, 0, z);
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", sb_q.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
